// File: rtl/axil_mem_bist_ctrl_if.sv
// AXI4-Lite bus bundle between the memory BIST master and the memory slave.
//   master modport : drives AW/W/AR channels and B/R ready
//   slave  modport : drives AW/W/AR ready and B/R response channels
// Addresses are 32-bit word addresses; DW is the data width, WSTRB is DW/8.
interface axil_mem_bist_ctrl_if #(
  parameter int DW = 32
);
  logic [31:0]   AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic [DW/8-1:0] WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [31:0]   ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_mem_bist_ctrl.sv
// AXI4-Lite master running a fill-then-verify pass over a word-addressed memory.
// Word i gets data pattern ^ i at address base_addr + i; all words are written,
// then read back and compared. Mismatches and non-OKAY responses are counted.
// Ports:
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   start                 start pulse, accepted only while idle
//   base_addr, word_count, pattern   pass parameters, captured at start
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   err_count             saturating error count, cleared at start
//   m_axil                AXI4-Lite master port
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start
// S_WR_ADDR | AW and W offered for word i, each dropped on its handshake
// S_WR_RESP | waiting for the B response of word i
// S_RD_ADDR | AR offered for word i
// S_RD_DATA | waiting for the R beat of word i, compare against pattern ^ i
// S_DONE    | end of pass: done pulse, busy low
module axil_mem_bist_ctrl #(
  parameter int DW    = 32,
  parameter int CNT_W = 9
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     word_count,
  input  logic [DW-1:0]        pattern,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  axil_mem_bist_ctrl_if.master m_axil
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic [DW-1:0]    pat_q, pat_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;

  logic [CNT_W-1:0] idx_nxt;
  logic             last_word;
  logic [CNT_W-1:0] err_inc;
  logic [DW-1:0]    exp_rdata;
  logic             aw_ok;
  logic             w_ok;

  always_comb begin
    idx_nxt   = idx_q + CNT_W'(1);
    last_word = (idx_nxt == cnt_q);
    err_inc   = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1);
    exp_rdata = pat_q ^ DW'(idx_q);
    // A channel counts as finished once its VALID has been dropped or is
    // being accepted this cycle.
    aw_ok     = !awvalid_q || m_axil.AWREADY;
    w_ok      = !wvalid_q  || m_axil.WREADY;

    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    pat_d     = pat_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          err_d  = '0;
          idx_d  = '0;
          cnt_d  = word_count;
          base_d = base_addr;
          pat_d  = pattern;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = base_addr;
            wdata_d   = pattern;
          end
        end
      end

      S_WR_ADDR: begin
        if (awvalid_q && m_axil.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.WREADY)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (m_axil.BVALID) begin
          bready_d = 1'b0;
          if (m_axil.BRESP != 2'b00) err_d = err_inc;
          if (last_word) begin
            idx_d     = '0;
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = base_q;
          end else begin
            idx_d     = idx_nxt;
            state_d   = S_WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = base_q + 32'(idx_nxt);
            wdata_d   = pat_q ^ DW'(idx_nxt);
          end
        end
      end

      S_RD_ADDR: begin
        if (m_axil.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axil.RVALID) begin
          rready_d = 1'b0;
          if ((m_axil.RRESP != 2'b00) || (m_axil.RDATA != exp_rdata)) err_d = err_inc;
          if (last_word) begin
            idx_d   = '0;
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_nxt;
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = base_q + 32'(idx_nxt);
          end
        end
      end

      S_DONE: begin
        // A zero-length pass arrives here with busy still high, so it spends
        // one extra cycle to give busy a full cycle before the done pulse.
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      pat_q     <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      pat_q     <= pat_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_q;
  assign m_axil.AWADDR  = awaddr_q;
  assign m_axil.AWVALID = awvalid_q;
  assign m_axil.WDATA   = wdata_q;
  assign m_axil.WSTRB   = {(DW/8){1'b1}};
  assign m_axil.WVALID  = wvalid_q;
  assign m_axil.BREADY  = bready_q;
  assign m_axil.ARADDR  = araddr_q;
  assign m_axil.ARVALID = arvalid_q;
  assign m_axil.RREADY  = rready_q;

endmodule
